// File: rtl/odo_pkg.sv
// odo_pkg: shared defaults and FSM encoding for the Odo rotation-mix engine.
package odo_pkg;
    localparam int ODO_NWORDS = 10;
    localparam int ODO_W = 64;
    localparam logic [31:0] ODO_ROTS = {8'd43, 8'd21, 8'd9, 8'd1};
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/odo_rot_word.sv
// odo_rot_word: H(x) = XOR of left rotations of one word by each ROTS tap.
module odo_rot_word
    import odo_pkg::*;
#(
    parameter int W = ODO_W,
    parameter int NROT = 4,
    parameter logic [8*NROT-1:0] ROTS = ODO_ROTS
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] h
);
    always_comb begin
        logic [2*W-1:0] d;
        h = '0;
        d = '0;
        for (int j = 0; j < NROT; j++) begin
            // upper half of {x,x} shifted left is rotl(x, r)
            d = {x, x} << ROTS[8*j +: 8];
            h = h ^ d[2*W-1:W];
        end
    end
endmodule

// File: rtl/odo_rotation_engine.sv
// odo_rotation_engine: iterative Odo rotate/neighbour-XOR mix, one round per clock.
// Optional ODO_ROT_PERF_CNT_EN adds jobs_done / busy_cycles counters.
module odo_rotation_engine
    import odo_pkg::*;
#(
    parameter int NWORDS = ODO_NWORDS,
    parameter int W = ODO_W,
    parameter int SHIFT = 1,
    parameter int NROT = 4,
    parameter logic [8*NROT-1:0] ROTS = ODO_ROTS,
    parameter int MAX_ROUNDS = 15,
    parameter int RW = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NWORDS*W-1:0]   in_state,
    input  logic [RW-1:0]         in_rounds,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NWORDS*W-1:0]   out_state,
    output logic                  busy
`ifdef ODO_ROT_PERF_CNT_EN
    ,
    output logic [31:0]           jobs_done,
    output logic [31:0]           busy_cycles
`endif
);
    logic [1:0] fsm;
    logic [NWORDS*W-1:0] state, hmix, mixed;
    logic [RW-1:0] cnt, load_cnt;
    logic accept;

    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        odo_rot_word #(.W(W), .NROT(NROT), .ROTS(ROTS)) u_rot (
            .x(state[W*i +: W]),
            .h(hmix[W*i +: W])
        );
        assign mixed[W*i +: W] = hmix[W*i +: W] ^ state[W*((i + SHIFT) % NWORDS) +: W];
    end

    assign in_ready = (fsm == ST_IDLE) || (fsm == ST_DONE && out_ready);
    assign out_valid = (fsm == ST_DONE);
    assign busy = (fsm == ST_RUN);
    assign out_state = state;
    assign accept = in_valid && in_ready;
    assign load_cnt = (in_rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : in_rounds;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= ST_IDLE;
            state <= '0;
            cnt <= '0;
        end else if (accept) begin
            state <= in_state;
            cnt <= load_cnt;
            fsm <= (load_cnt == '0) ? ST_DONE : ST_RUN;
        end else if (fsm == ST_RUN) begin
            state <= mixed;
            cnt <= cnt - RW'(1);
            if (cnt == RW'(1)) fsm <= ST_DONE;
        end else if (out_valid && out_ready) begin
            fsm <= ST_IDLE;
        end
    end

`ifdef ODO_ROT_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jobs_done <= '0;
            busy_cycles <= '0;
        end else begin
            if (out_valid && out_ready) jobs_done <= jobs_done + 32'd1;
            if (busy) busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_odo_rotation_engine.sv
// tb_odo_rotation_engine: directed scoreboard bench for odo_rotation_engine (default build).
module tb_odo_rotation_engine;
    localparam int SW = 640;

    typedef struct {
        logic [SW-1:0] st;
        int cyc;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [SW-1:0] in_state = '0, out_state;
    logic [3:0] in_rounds = '0;

    int total = 0, bad = 0, cyc = 0;
    exp_t q[$];
    bit pv = 0, pp = 0;

    odo_rotation_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_rounds(in_rounds), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] hh(input logic [63:0] x);
        int r[4] = '{1, 9, 21, 43};
        hh = '0;
        foreach (r[k]) hh = hh ^ ((x << r[k]) | (x >> (64 - r[k])));
    endfunction

    function automatic logic [SW-1:0] model(input logic [SW-1:0] s, input int n);
        logic [SW-1:0] o;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 10; i++) o[64*i +: 64] = hh(s[64*i +: 64]) ^ s[64*((i + 1) % 10) +: 64];
            s = o;
        end
        return s;
    endfunction

    function automatic logic [SW-1:0] rnd();
        logic [SW-1:0] s;
        for (int k = 0; k < 20; k++) s[32*k +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [SW-1:0] o, input logic [SW-1:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // leaves in_valid high so a following send presents back-to-back
    task automatic send(input logic [SW-1:0] st, input int r, input logic [SW-1:0] e, output int acc);
        in_state = st;
        in_rounds = r[3:0];
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
        chk("accept_timeout", in_ready, 1'b1);
        acc = cyc;
        q.push_back('{e, cyc + 1 + r});
        @(negedge clk);
    endtask

    task automatic drain(input bit no_busy);
        for (int k = 0; k < 300 && q.size() != 0; k++) begin
            if (no_busy) chk("busy_low", busy, 1'b0);
            @(negedge clk);
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    always @(negedge clk) begin
        #3;
        if (rst) begin
            pv = 0;
            pp = 0;
        end else begin
            if (out_valid && (!pv || pp)) begin
                chk("unexpected_out", q.size() != 0, 1'b1);
                if (q.size() != 0) chk("latency", cyc, q[0].cyc);
            end
            if (out_valid && out_ready && q.size() != 0) begin
                chk("result", out_state, q[0].st);
                void'(q.pop_front());
            end
            pv = out_valid;
            pp = out_valid && out_ready;
        end
    end

    initial begin
        int a1, a2;
        logic [SW-1:0] s, e;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_state", out_state, '0);

        send(SW'(1), 1, {64'h1, 512'h0, 64'h0000080000200202}, a1);
        in_valid = 1'b0;
        drain(0);

        s = rnd();
        send(s, 0, s, a1);
        in_valid = 1'b0;
        drain(1);

        s = rnd();
        e = model(s, 15);
        out_ready = 1'b0;
        send(s, 15, e, a1);
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !out_valid; k++) begin
            chk("run_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_state", out_state, e);
            chk("stall_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain(0);

        s = rnd();
        send(s, 3, model(s, 3), a1);
        s = rnd();
        send(s, 2, model(s, 2), a2);
        in_valid = 1'b0;
        chk("no_bubble", a2, a1 + 4);
        drain(0);

        s = rnd();
        send(s, 10, model(s, 10), a1);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_state", out_state, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        s = rnd();
        send(s, 7, model(s, 7), a1);
        in_valid = 1'b0;
        drain(0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
